// File: rtl/keypad_if.sv
// Keypad matrix lines and decoded key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row,
        output col, key_code, key_valid, key_down
    );
    modport slave (
        output row,
        input  col, key_code, key_valid, key_down
    );
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with debounced press and release.
// One key code is reported per accepted press.
module keypad_scan_4x4 #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master kp
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [3:0] DB_N = 4'(DEBOUNCE);

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_DEB  = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sync_q, sync_d;
    logic [3:0]    rs_q, rs_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    db_cnt_q, db_cnt_d;
    logic [3:0]    rel_cnt_q, rel_cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          down_q, down_d;

    logic       tick;
    logic       hit;
    logic       acc;
    logic [1:0] row_idx;
    logic [3:0] cand;

    always_comb begin
        tick = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        sync_d = kp.row;
        rs_d = sync_q;
        hit = (rs_q != 4'hF);
        // Lowest-numbered low row wins when several keys share a column.
        if (!rs_q[0])      row_idx = 2'd0;
        else if (!rs_q[1]) row_idx = 2'd1;
        else if (!rs_q[2]) row_idx = 2'd2;
        else               row_idx = 2'd3;
        cand = {row_idx, col_idx_q};

        col_idx_d = col_idx_q;
        state_d   = state_q;
        pend_d    = pend_q;
        db_cnt_d  = db_cnt_q;
        rel_cnt_d = rel_cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        down_d    = down_q;
        acc       = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (hit) begin
                        pend_d   = cand;
                        db_cnt_d = 4'd1;
                        if (DB_N == 4'd1) acc = 1'b1;
                        else state_d = ST_DEB;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEB: begin
                    if (hit && cand == pend_q) begin
                        db_cnt_d = db_cnt_q + 4'd1;
                        if (db_cnt_q + 4'd1 == DB_N) acc = 1'b1;
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (!hit) begin
                        rel_cnt_d = rel_cnt_q + 4'd1;
                        if (rel_cnt_q + 4'd1 == DB_N) begin
                            down_d    = 1'b0;
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        rel_cnt_d = 4'd0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        if (acc) begin
            code_d    = cand;
            valid_d   = 1'b1;
            down_d    = 1'b1;
            rel_cnt_d = 4'd0;
            state_d   = ST_HELD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sync_q    <= 4'hF;
            rs_q      <= 4'hF;
            col_idx_q <= 2'd0;
            state_q   <= ST_SCAN;
            pend_q    <= 4'd0;
            db_cnt_q  <= 4'd0;
            rel_cnt_q <= 4'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            rs_q      <= rs_d;
            col_idx_q <= col_idx_d;
            state_q   <= state_d;
            pend_q    <= pend_d;
            db_cnt_q  <= db_cnt_d;
            rel_cnt_q <= rel_cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            down_q    <= down_d;
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_down  = down_q;
endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time and reading the four row lines.
- Debounces both key press and key release, then reports one key code per press.
- This is the input-side counterpart of the board's multiplexed 7-segment display drivers, which drive digit-select lines and segment data.
- The output feeds the lab display/control logic.

Parameters:
- SCAN_DIV, 100000, clk cycles per scan tick (column dwell time); legal range >= 4.
- DEBOUNCE, 4, consecutive ticks a press or release must be stable before it is accepted; legal range 1..15.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- row, input, 4, keypad row lines; active-low, externally pulled up.
- col, output, 4, keypad column drive; exactly one bit low, all others high.
- key_code, output, 4, code of the last accepted key, equal to row_idx*4 + col_idx.
- key_valid, output, 1, one-clk pulse when a new key is accepted.
- key_down, output, 1, level that is high from acceptance until release is debounced.

Behaviour:
- Reset: synchronous; sampled on posedge clk while rst_n==0.
  - Tick counter = 0; synchronizer = 4'b1111; col_idx = 0; col = 4'b1110.
  - state = SCAN; key_code = 0; key_valid = 0; key_down = 0; debounce counters = 0.
  - Reset asserted mid-press or mid-hold aborts immediately. No key_valid pulse is emitted on or after reset.
- Tick: counter runs 0..SCAN_DIV-1 and wraps. tick = 1 for the single cycle where counter == SCAN_DIV-1. All FSM decisions occur only on tick cycles.
- Row sampling: row passes through a 2-flop synchronizer (rs). Decisions use rs, so rows must be stable at least 2 cycles before the tick.
- Column drive: col = ~(4'b0001 << col_idx). col_idx changes only on a tick and only in the transitions noted below.
- Row decode:
  - hit = (rs != 4'b1111).
  - row_idx = lowest index i with rs[i]==0; lowest index wins when several rows are low.
  - cand = {row_idx, col_idx} (4 bits).
- SCAN (on tick):
  - If hit: latch cand into pend_code, set db_cnt = 1, go to DEBOUNCE. col_idx is frozen.
  - Else: col_idx = col_idx+1, wrapping 3->0.
  - If DEBOUNCE==1, the hit tick accepts immediately (same actions as acceptance below).
- DEBOUNCE (on tick, col frozen):
  - If hit and cand==pend_code: db_cnt++. When db_cnt reaches DEBOUNCE, accept:
    - key_code = pend_code; key_valid = 1 for exactly the next clk cycle; key_down = 1.
    - rel_cnt = 0; go to HELD.
  - Else (no hit or different code): discard, go to SCAN, col_idx++.
- HELD (on tick, col frozen):
  - If !hit: rel_cnt++. When rel_cnt reaches DEBOUNCE: key_down = 0, go to SCAN, col_idx++.
  - If hit: rel_cnt = 0. Any code change while held is ignored (no new key_valid).
- key_valid is registered and high for one clk only, never two consecutive cycles.
- key_code holds its value until the next acceptance.
- Keys in other columns pressed during HELD are not seen, because the column is frozen.
- Simultaneous keys in the same column: the lowest row wins, consistently across ticks.
- Latency from a stable press in the active column: key_valid asserts 1 clk after the DEBOUNCE-th qualifying tick.

Test Plan:
(All scenarios use SCAN_DIV=8, DEBOUNCE=3.)
1. Reset release, no keys -> col cycles 1110, 1101, 1011, 0111, 1110, each held 8 clks; key_valid stays 0; key_code = 0.
2. Key row 2 / col 1 held 200 clks, then released -> exactly one key_valid pulse with key_code = 9. key_down = 1 until 3 consecutive released ticks have passed, then 0 and scanning resumes from col_idx 2.
3. Bounce: row 1 low for 1 tick, high for 1 tick, low for 1 tick, then released, all in col 0 -> no key_valid, FSM returns to SCAN.
4. Row 0 and row 3 both low in col 3 -> key_code = 3 (lowest row wins); one pulse only.
5. Key held, then a 1-tick release glitch in HELD -> no second key_valid; key_down stays 1.
6. rst_n = 0 asserted for 1 clk during DEBOUNCE and during HELD -> next cycle col = 1110, key_down = 0, key_valid = 0, key_code = 0. Pressing after reset requires a full debounce.
